// File: rtl/counter_prog.sv
// -----------------------------------------------------------------------------
// counter_prog
//
// Loadable up/down counter with a programmable terminal count (MAX_VAL).
// It supports wrap or saturate behaviour at the limits, a count-enable
// prescaler and a one-cycle terminal-count pulse.
//
// Parameters:
//   WIDTH     - counter width in bits
//   MAX_VAL   - highest count value, 1 .. 2**WIDTH-1
//   PRESCALE  - enabled cycles per count step, >= 1
//   RESET_VAL - value loaded by RESET / CLEAR, <= MAX_VAL
//
// Ports:
//   CLK       in   clock, rising edge
//   RESET     in   synchronous active-high reset
//   CLEAR     in   synchronous clear to RESET_VAL
//   LOAD_EN   in   load LOAD_DATA (clamped to MAX_VAL)
//   LOAD_DATA in   load value
//   COUNT_EN  in   count enable, qualified by the prescaler
//   UP_DN     in   1 = count up, 0 = count down
//   SAT_MODE  in   1 = saturate at the limit, 0 = wrap
//   Q_OUT     out  registered count
//   TC        out  registered terminal-count pulse
//   AT_LIMIT  out  combinational: Q_OUT is at the limit for the current UP_DN
// -----------------------------------------------------------------------------
module counter_prog #(
    parameter int WIDTH     = 16,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             LOAD_EN,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             COUNT_EN,
    input  logic             UP_DN,
    input  logic             SAT_MODE,
    output logic [WIDTH-1:0] Q_OUT,
    output logic             TC,
    output logic             AT_LIMIT
);

    // Reject parameter sets that would let Q_OUT leave 0..MAX_VAL.
    generate
        if (MAX_VAL < 1 || longint'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_max
            $error("counter_prog: MAX_VAL out of range");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $error("counter_prog: PRESCALE must be >= 1");
        end
        if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_rst
            $error("counter_prog: RESET_VAL must be within 0..MAX_VAL");
        end
    endgenerate

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VAL);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0] q_q,   q_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tc_q,  tc_d;

    always_comb begin
        q_d   = q_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        if (CLEAR) begin
            q_d   = RST_V;
            pre_d = '0;
        end else if (LOAD_EN) begin
            // Out-of-range loads clamp so Q_OUT can never exceed MAX_VAL.
            q_d   = (LOAD_DATA > MAX_V) ? MAX_V : LOAD_DATA;
            pre_d = '0;
        end else if (COUNT_EN) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (UP_DN) begin
                    if (q_q == MAX_V) begin
                        // Step from the limit: wrap or hold, pulse TC either way.
                        q_d  = SAT_MODE ? MAX_V : '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end else begin
                    if (q_q == '0) begin
                        q_d  = SAT_MODE ? '0 : MAX_V;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q   <= RST_V;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
        end
    end

    assign Q_OUT    = q_q;
    assign TC       = tc_q;
    assign AT_LIMIT = UP_DN ? (q_q == MAX_V) : (q_q == '0);

endmodule

// File: tb/tb_counter_prog.sv
// -----------------------------------------------------------------------------
// tb_counter_prog
//
// Directed bench for counter_prog with WIDTH=4, MAX_VAL=9, PRESCALE=3,
// RESET_VAL=0. Expected Q_OUT sequences are hand-computed and queued in
// exp_q, then popped one per clock edge. Other outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_counter_prog;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         load_en;
    logic [W-1:0] load_data;
    logic         count_en;
    logic         up_dn;
    logic         sat_mode;
    logic [W-1:0] q_out;
    logic         tc;
    logic         at_limit;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    counter_prog #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .PRESCALE  (3),
        .RESET_VAL (0)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .CLEAR     (clear),
        .LOAD_EN   (load_en),
        .LOAD_DATA (load_data),
        .COUNT_EN  (count_en),
        .UP_DN     (up_dn),
        .SAT_MODE  (sat_mode),
        .Q_OUT     (q_out),
        .TC        (tc),
        .AT_LIMIT  (at_limit)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Advance one active edge and settle; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] val);
        load_en   = 1'b1;
        load_data = val;
        count_en  = 1'b0;
        tick();
        load_en   = 1'b0;
    endtask

    // Drive n enabled edges, popping one expected Q_OUT per edge.
    task automatic run_en(input int n, input string tag);
        count_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 8'd1, 8'd0);
            end else begin
                check(tag, 8'(q_out), 8'(exp_q.pop_front()));
            end
        end
        count_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        load_en   = 1'b0;
        load_data = '0;
        count_en  = 1'b1;
        up_dn     = 1'b1;
        sat_mode  = 1'b0;

        // Reset held with COUNT_EN asserted: nothing moves.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_q",  8'(q_out), 8'd0);
            check("reset_tc", 8'(tc),    8'd0);
        end
        check("reset_atlim_up", 8'(at_limit), 8'd0);

        // Prescale by 3: steps after the 3rd and 6th enabled edges.
        reset = 1'b0;
        exp_q = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        run_en(6, "prescale_q");
        check("prescale_tc", 8'(tc), 8'd0);

        // Up wrap from 9.
        sat_mode = 1'b0;
        up_dn    = 1'b1;
        load(4'd9);
        check("upwrap_load_q",  8'(q_out),    8'd9);
        check("upwrap_atlim_0", 8'(at_limit), 8'd1);
        exp_q = '{4'd9, 4'd9, 4'd0};
        run_en(3, "upwrap_q");
        check("upwrap_tc",      8'(tc),       8'd1);
        check("upwrap_atlim_1", 8'(at_limit), 8'd0);
        tick();
        check("upwrap_tc_fall", 8'(tc),    8'd0);
        check("upwrap_hold_q",  8'(q_out), 8'd0);

        // Down saturate at 0: TC pulses after 3rd and 6th edges.
        sat_mode = 1'b1;
        up_dn    = 1'b0;
        load(4'd0);
        check("dnsat_atlim_0", 8'(at_limit), 8'd1);
        count_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("dnsat_q",     8'(q_out),    8'd0);
            check("dnsat_atlim", 8'(at_limit), 8'd1);
            check("dnsat_tc",    8'(tc),       (i == 3 || i == 6) ? 8'd1 : 8'd0);
        end
        count_en = 1'b0;
        tick();
        check("dnsat_tc_fall", 8'(tc), 8'd0);

        // Down wrap from 0 to 9.
        sat_mode = 1'b0;
        up_dn    = 1'b0;
        load(4'd0);
        exp_q = '{4'd0, 4'd0, 4'd9};
        run_en(3, "dnwrap_q");
        check("dnwrap_tc",    8'(tc),       8'd1);
        check("dnwrap_atlim", 8'(at_limit), 8'd0);
        tick();
        check("dnwrap_tc_fall", 8'(tc), 8'd0);

        // Priority and clamp: load beats count, clear beats load.
        load_en   = 1'b1;
        load_data = 4'd14;
        count_en  = 1'b1;
        tick();
        check("clamp_q",  8'(q_out), 8'd9);
        check("clamp_tc", 8'(tc),    8'd0);
        clear     = 1'b1;
        load_data = 4'd5;
        tick();
        check("clear_q", 8'(q_out), 8'd0);
        clear    = 1'b0;
        load_en  = 1'b0;
        count_en = 1'b0;

        // Load restarts the prescaler.
        up_dn = 1'b1;
        exp_q = '{4'd0, 4'd0};
        run_en(2, "restart_pre_q");
        load(4'd5);
        check("restart_load_q", 8'(q_out), 8'd5);
        exp_q = '{4'd5, 4'd5, 4'd6};
        run_en(3, "restart_q");

        // Non-contiguous enables still count toward the prescale.
        for (int i = 0; i < 3; i++) begin
            count_en = 1'b1;
            tick();
            count_en = 1'b0;
            tick();
        end
        check("gapped_q", 8'(q_out), 8'd7);

        // Direction change mid-prescale does not disturb pre.
        count_en = 1'b1;
        tick();
        tick();
        up_dn = 1'b0;
        tick();
        check("dirchg_q", 8'(q_out), 8'd6);
        count_en = 1'b0;

        // Up saturate at 9 holds and pulses TC.
        sat_mode = 1'b1;
        up_dn    = 1'b1;
        load(4'd9);
        exp_q = '{4'd9, 4'd9, 4'd9};
        run_en(3, "upsat_q");
        check("upsat_tc", 8'(tc), 8'd1);

        // Reset mid-prescale: nothing pending survives.
        load(4'd3);
        count_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midreset_q",  8'(q_out), 8'd0);
        check("midreset_tc", 8'(tc),    8'd0);
        reset = 1'b0;
        exp_q = '{4'd0, 4'd0, 4'd1};
        run_en(3, "midreset_pre_q");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_prog.md
# counter_prog

Parametrised, loadable up/down counter with programmable modulus, wrap or saturate mode, count-enable prescaler and a terminal-count pulse. It generalises the team's fixed-width loadable counters into a single configurable block. Typical uses are round and timeout counters, sequence-index counters and divided-rate tick counters in the memory-game datapath and its microprogram control. Clocking is single-domain.

## Interface
- WIDTH, 16: counter width in bits.
- MAX_VAL, 2**WIDTH-1: terminal (highest) count. Legal range is 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- PRESCALE, 1: number of COUNT_EN cycles per count step. PRESCALE ≥ 1; 1 means a step on every enabled cycle.
- RESET_VAL, 0: value loaded by RESET and CLEAR. Must satisfy RESET_VAL ≤ MAX_VAL.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- CLEAR  in  1  synchronous clear to RESET_VAL.
- LOAD_EN  in  1  load LOAD_DATA.
- LOAD_DATA  in  WIDTH  load value.
- COUNT_EN  in  1  count enable, qualified by the prescaler.
- UP_DN  in  1  direction: 1 = up, 0 = down.
- SAT_MODE  in  1  limit behaviour: 1 = saturate, 0 = wrap.
- Q_OUT  out  WIDTH  current count (registered).
- TC  out  1  terminal-count pulse (registered, one cycle).
- AT_LIMIT  out  1  combinational. Equals (Q_OUT==MAX_VAL) when UP_DN=1, and (Q_OUT==0) when UP_DN=0.

## Operation
- Internal state:
  - Q_OUT.
  - Prescale counter `pre`, range 0..PRESCALE-1, width clog2(PRESCALE) (minimum 1 bit).
  - TC register.
- Priority per edge: RESET > CLEAR > LOAD_EN > step > hold.
- RESET or CLEAR: Q_OUT=RESET_VAL, pre=0, TC=0.
- LOAD_EN:
  - Q_OUT = min(LOAD_DATA, MAX_VAL), so out-of-range loads clamp to MAX_VAL.
  - pre=0, TC=0.
  - COUNT_EN in the same cycle is ignored.
- COUNT_EN=1 with no higher-priority event:
  - If pre==PRESCALE-1: a step occurs and pre=0.
  - Otherwise: pre increments and Q_OUT holds.
- Step, up (UP_DN=1):
  - Q_OUT<MAX_VAL: Q_OUT+1.
  - Q_OUT==MAX_VAL: becomes 0 if SAT_MODE=0, holds MAX_VAL if SAT_MODE=1.
- Step, down (UP_DN=0):
  - Q_OUT>0: Q_OUT-1.
  - Q_OUT==0: becomes MAX_VAL if SAT_MODE=0, holds 0 if SAT_MODE=1.
- TC=1 for exactly the cycle after any step taken from the limit value, in both wrap and saturate mode. Otherwise TC=0.
  - In saturate mode, each further step at the limit pulses TC again.
- COUNT_EN=0: Q_OUT and pre hold; TC=0.
- UP_DN and SAT_MODE are sampled only at step edges. Changing them does not disturb pre.
- Arithmetic is WIDTH-bit. Q_OUT never exceeds MAX_VAL: it is unreachable, since all paths clamp or wrap.
- Illegal parameters (MAX_VAL=0, MAX_VAL ≥ 2**WIDTH, PRESCALE=0, RESET_VAL>MAX_VAL) are rejected at elaboration by a generate-time error.

## Timing
- Latency:
  - Enable, load or clear to Q_OUT change: 1 edge.
  - With PRESCALE=N from pre=0, the first step appears on Q_OUT after the Nth consecutive enabled edge. Enabled cycles need not be contiguous.
- TC rises on the same edge the wrapped or held Q_OUT value is presented. It falls on the next edge unless another limit step occurs.
- AT_LIMIT follows Q_OUT and UP_DN combinationally, with no register delay.
- Reset values: Q_OUT=RESET_VAL, TC=0, AT_LIMIT per the formula (e.g. 1 if RESET_VAL=0 and UP_DN=0).
- Reset mid-prescale or mid-load: the RESET edge wins outright. Nothing pending survives.
- No combinational path from any input to Q_OUT or TC.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, PRESCALE=3, RESET_VAL=0.
- Reset/prescale: RESET=1 with COUNT_EN=1 for 2 cycles, then RESET=0 and COUNT_EN=1 for 6 cycles, UP_DN=1.
  - Required: Q_OUT=0 and TC=0 during reset; Q_OUT goes 0→1 after the 3rd enabled edge and 1→2 after the 6th.
- Up wrap: LOAD 9, SAT_MODE=0, UP_DN=1, 3 enabled cycles.
  - Required: Q_OUT=0, TC=1 for one cycle; AT_LIMIT=1 before the step, 0 after.
- Down saturate: LOAD 0, SAT_MODE=1, UP_DN=0, 6 enabled cycles.
  - Required: Q_OUT stays 0, TC pulses after the 3rd and 6th edges, AT_LIMIT=1 throughout.
- Down wrap: LOAD 0, SAT_MODE=0, UP_DN=0, 3 enabled cycles.
  - Required: Q_OUT=9, TC=1 for one cycle.
- Priority/clamp:
  - LOAD_EN=1, LOAD_DATA=14, COUNT_EN=1 → Q_OUT=9.
  - Next cycle CLEAR=1 with LOAD_EN=1, LOAD_DATA=5 → Q_OUT=0.
- Prescaler restart: from Q_OUT=0 give 2 enabled cycles, then LOAD 5, then 2 enabled cycles.
  - Required: Q_OUT=5 is held; a 3rd enabled cycle gives Q_OUT=6.
